mem_bus_arbiter: RTL

//   Shares one memory port between the CPU instruction-fetch master and data master.

---
 rtl/mem_bus_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (inst fetch / data) to single memory port arbiter with round-robin under contention
// and a watchdog that force-completes hung slave transactions; grant is registered, one per transaction.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inst_read,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_stall,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_mask,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    logic gnt_i, gnt_d, strobe, data_req, ack, timeout, done;

    assign gnt_i    = (state_q == ST_GNT_I);
    assign gnt_d    = (state_q == ST_GNT_D);
    assign strobe   = gnt_i | gnt_d;
    assign data_req = data_read | data_write;
    // An ack outside a grant has no transaction to complete, so it is masked here.
    assign ack      = strobe & mem_ack;
    assign timeout  = strobe & ~mem_ack & (cnt_q == CNT_LAST);
    assign done     = ack | timeout;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | timeout;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (data_req) begin
                    state_d = ST_GNT_D;
                end else if (inst_read) begin
                    state_d = ST_GNT_I;
                end
            end
            ST_GNT_I: begin
                if (done) begin
                    cnt_d   = '0;
                    state_d = data_req ? ST_GNT_D : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GNT_D: begin
                if (done) begin
                    cnt_d   = '0;
                    state_d = inst_read ? ST_GNT_I : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        mem_read   = gnt_i | (gnt_d & ~data_write);
        mem_write  = gnt_d & data_write;
        mem_addr   = gnt_i ? inst_addr : (gnt_d ? data_addr : '0);
        mem_wdata  = (gnt_d & data_write) ? data_wdata : '0;
        mem_mask   = (gnt_d & data_write) ? data_mask : (strobe ? '1 : '0);
        inst_rdata = (gnt_i & ack & inst_read) ? mem_rdata : '0;
        data_rdata = (gnt_d & ack & data_read & ~data_write) ? mem_rdata : '0;
        inst_stall = inst_read & ~(gnt_i & done);
        data_stall = data_req & ~(gnt_d & done);
        bus_err    = bus_err_q;
    end

endmodule
